// File: rtl/round_robin_demux_if.sv
// Bundles the TDM sample input and the de-interleaved frame output of round_robin_demux.
// din is a valid-only stream with no ready signal. A beat transfers on every rising
// edge where din_valid=1, and din_sof is meaningful only on such beats. The consumer
// takes dout as qualified by the one-cycle dout_valid strobe.
interface round_robin_demux_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLOTS  = 2
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_sof;
  logic [DATA_WIDTH-1:0] dout [NUM_SLOTS];
  logic                  dout_valid;
  logic                  locked;
  logic                  align_err;
  logic [7:0]            err_count;

  modport master (
    output din, din_valid, din_sof,
    input  dout, dout_valid, locked, align_err, err_count
  );

  modport slave (
    input  din, din_valid, din_sof,
    output dout, dout_valid, locked, align_err, err_count
  );
endinterface

// File: rtl/round_robin_demux.sv
// De-interleaves a TDM sample stream into NUM_SLOTS parallel lanes, tracking frame
// alignment from the slot-0 marker. A complete frame is presented with a one-cycle strobe.
module round_robin_demux #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLOTS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  round_robin_demux_if.slave  bus
);
  localparam int CW = $clog2(NUM_SLOTS);
  localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_SLOTS - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         slot_cnt_q, slot_cnt_d;
  logic [DATA_WIDTH-1:0] shadow_q [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] shadow_d [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] dout_q   [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] dout_d   [NUM_SLOTS];
  logic                  dout_valid_q, dout_valid_d;
  logic                  locked_q, locked_d;
  logic                  align_err_q, align_err_d;
  logic [7:0]            err_count_q, err_count_d;

  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    align_err_d  = 1'b0;
    err_count_d  = err_count_q;

    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          // Non-marker beats are noise while hunting, not framing errors.
          if (bus.din_sof) begin
            shadow_d[0] = bus.din;
            slot_cnt_d  = CW'(1);
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (slot_cnt_q == '0) begin
            if (bus.din_sof) begin
              shadow_d[0] = bus.din;
              slot_cnt_d  = CW'(1);
            end else begin
              align_err_d = 1'b1;
              state_d     = HUNT;
            end
          end else if (bus.din_sof) begin
            // Early marker: abandon the partial frame and restart on this beat.
            align_err_d = 1'b1;
            shadow_d[0] = bus.din;
            slot_cnt_d  = CW'(1);
          end else begin
            shadow_d[slot_cnt_q] = bus.din;
            if (slot_cnt_q == LAST_SLOT) begin
              for (int k = 0; k < NUM_SLOTS - 1; k++) dout_d[k] = shadow_q[k];
              dout_d[NUM_SLOTS-1] = bus.din;
              dout_valid_d        = 1'b1;
              slot_cnt_d          = '0;
            end else begin
              slot_cnt_d = slot_cnt_q + CW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (align_err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      slot_cnt_q   <= '0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      align_err_q  <= 1'b0;
      err_count_q  <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        shadow_q[k] <= '0;
        dout_q[k]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      locked_q     <= locked_d;
      align_err_q  <= align_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.locked     = locked_q;
  assign bus.align_err  = align_err_q;
  assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_round_robin_demux.sv
// Self-checking bench for round_robin_demux: a 2-slot and a 4-slot instance, with expected
// frames queued as beats are driven and popped as dout_valid strobes appear.
module tb_round_robin_demux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  round_robin_demux_if #(.DATA_WIDTH(8), .NUM_SLOTS(2)) bus2 ();
  round_robin_demux_if #(.DATA_WIDTH(8), .NUM_SLOTS(4)) bus4 ();

  round_robin_demux #(.DATA_WIDTH(8), .NUM_SLOTS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  round_robin_demux #(.DATA_WIDTH(8), .NUM_SLOTS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen2 = 0;
  int err_seen4 = 0;
  int err_base;
  logic [15:0] exp_q2[$];
  logic [31:0] exp_q4[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pack2();
    return {bus2.dout[1], bus2.dout[0]};
  endfunction

  function automatic logic [31:0] pack4();
    return {bus4.dout[3], bus4.dout[2], bus4.dout[1], bus4.dout[0]};
  endfunction

  // Scoreboard: compare every frame strobe against the queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus2.dout_valid) begin
        if (exp_q2.size() == 0) check("dv2_unexpected", 32'd1, 32'd0);
        else check("dout2", {16'd0, pack2()}, {16'd0, exp_q2.pop_front()});
      end
      if (bus4.dout_valid) begin
        if (exp_q4.size() == 0) check("dv4_unexpected", 32'd1, 32'd0);
        else check("dout4", pack4(), exp_q4.pop_front());
      end
      if (bus2.align_err) err_seen2++;
      if (bus4.align_err) err_seen4++;
    end
  end

  task automatic beat2(input logic [7:0] d, input logic sof);
    @(posedge clk); #1;
    bus2.din = d; bus2.din_sof = sof; bus2.din_valid = 1'b1;
  endtask

  task automatic idle2();
    @(posedge clk); #1;
    bus2.din = 8'($urandom_range(0, 255)); bus2.din_sof = 1'($urandom_range(0, 1));
    bus2.din_valid = 1'b0;
  endtask

  task automatic beat4(input logic [7:0] d, input logic sof);
    @(posedge clk); #1;
    bus4.din = d; bus4.din_sof = sof; bus4.din_valid = 1'b1;
  endtask

  task automatic idle4();
    @(posedge clk); #1;
    bus4.din = 8'h00; bus4.din_sof = 1'b0; bus4.din_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus2.din_valid = 1'b0; bus4.din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    err_seen2 = 0;
    err_seen4 = 0;
  endtask

  initial begin
    logic [7:0] a, b;
    bus2.din = '0; bus2.din_valid = 1'b0; bus2.din_sof = 1'b0;
    bus4.din = '0; bus4.din_valid = 1'b0; bus4.din_sof = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_locked", {31'd0, bus2.locked}, 32'd0);
    check("rst_dv", {31'd0, bus2.dout_valid}, 32'd0);
    check("rst_dout", {16'd0, pack2()}, 32'd0);
    check("rst_errcnt", {24'd0, bus2.err_count}, 32'd0);

    // Lock and de-interleave
    exp_q2.push_back(16'h2211);
    exp_q2.push_back(16'h4433);
    beat2(8'h11, 1'b1);
    check("pre_lock", {31'd0, bus2.locked}, 32'd0);
    beat2(8'h22, 1'b0);
    check("lock_rise", {31'd0, bus2.locked}, 32'd1);
    beat2(8'h33, 1'b1);
    check("dv_lat1", {31'd0, bus2.dout_valid}, 32'd1);
    beat2(8'h44, 1'b0);
    check("dv_gap", {31'd0, bus2.dout_valid}, 32'd0);
    check("locked_hold", {31'd0, bus2.locked}, 32'd1);
    idle2();
    check("dv_lat2", {31'd0, bus2.dout_valid}, 32'd1);
    idle2();

    // Hunt discard
    do_reset();
    exp_q2.push_back(16'h0201);
    beat2(8'hAA, 1'b0);
    beat2(8'hBB, 1'b0);
    beat2(8'h01, 1'b1);
    check("hunt_locked", {31'd0, bus2.locked}, 32'd0);
    beat2(8'h02, 1'b0);
    idle2();
    idle2();
    check("hunt_no_err", err_seen2, 32'd0);
    check("hunt_dout", {16'd0, pack2()}, 32'h0201);

    // Gaps mid-frame
    exp_q2.push_back(16'h0605);
    beat2(8'h05, 1'b1);
    repeat (3) begin
      idle2();
      check("gap_hold", {16'd0, pack2()}, 32'h0201);
    end
    beat2(8'h06, 1'b0);
    idle2();
    check("gap_dv", {31'd0, bus2.dout_valid}, 32'd1);
    idle2();

    // Early marker on the 4-slot instance
    exp_q4.push_back(32'h60504030);
    beat4(8'h10, 1'b1);
    beat4(8'h20, 1'b0);
    beat4(8'h30, 1'b1);
    beat4(8'h40, 1'b0);
    check("early_err", {31'd0, bus4.align_err}, 32'd1);
    beat4(8'h50, 1'b0);
    check("early_err_pulse", {31'd0, bus4.align_err}, 32'd0);
    beat4(8'h60, 1'b0);
    check("early_no_dv", {31'd0, bus4.dout_valid}, 32'd0);
    idle4();
    idle4();
    check("early_locked", {31'd0, bus4.locked}, 32'd1);
    check("early_errcnt", {24'd0, bus4.err_count}, 32'd1);
    check("early_dout", pack4(), 32'h60504030);

    // Missing marker (2-slot is locked at slot 0 after a complete frame)
    beat2(8'h07, 1'b0);
    idle2();
    check("miss_err", {31'd0, bus2.align_err}, 32'd1);
    check("miss_unlock", {31'd0, bus2.locked}, 32'd0);
    check("miss_errcnt", {24'd0, bus2.err_count}, 32'd1);
    idle2();

    // Saturation: 300 more missing-marker events
    err_base = err_seen2;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      exp_q2.push_back({b, a});
      beat2(a, 1'b1);
      beat2(b, 1'b0);
      beat2(8'($urandom_range(0, 255)), 1'b0);
    end
    idle2();
    idle2();
    check("sat_pulses", err_seen2 - err_base, 32'd300);
    check("sat_errcnt", {24'd0, bus2.err_count}, 32'd255);

    // Reset coincident with a valid sof beat
    @(posedge clk); #1;
    rst = 1'b1;
    bus2.din = 8'h77; bus2.din_sof = 1'b1; bus2.din_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus2.din_valid = 1'b0;
    check("rst2_errcnt", {24'd0, bus2.err_count}, 32'd0);
    check("rst2_locked", {31'd0, bus2.locked}, 32'd0);
    check("rst2_dout", {16'd0, pack2()}, 32'd0);
    check("rst2_dv", {31'd0, bus2.dout_valid}, 32'd0);
    check("rst2_aerr", {31'd0, bus2.align_err}, 32'd0);
    err_seen2 = 0;
    // If the 0x77 beat had been taken, this beat would complete a frame.
    beat2(8'h99, 1'b0);
    exp_q2.push_back(16'hBCAB);
    beat2(8'hAB, 1'b1);
    beat2(8'hBC, 1'b0);
    idle2();
    idle2();
    check("post_rst_dout", {16'd0, pack2()}, 32'hBCAB);
    check("post_rst_noerr", err_seen2, 32'd0);

    check("q2_empty", exp_q2.size(), 32'd0);
    check("q4_empty", exp_q4.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
